// File: rtl/fetch_unit.sv
// Instruction-fetch stage. It holds the PC and drives the instruction memory address.
// It registers the returned word into the IF/ID register, with valid/ready back-pressure.
// Redirects flush the stage and load a new PC. Fetching past the end of memory halts the stage.
// Optional feature macro: FETCH_ALIGN_CHECK_EN. When it is defined, a misaligned redirect
// halts the stage. When it is undefined, the low two bits of the redirect target are dropped.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        fault_o,
  output logic        misalign_o
);

  localparam logic [31:0] LastWordAddr = 32'(MEM_BYTES - 4);
  localparam logic [31:0] NopInstr     = 32'h0000_0013;

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;

  logic        capture;          // IF/ID slot is free (empty or being consumed) while running
  logic        in_range;         // current PC addresses a legal word
  logic        bad_align;        // redirect target must halt as misaligned
  logic [31:0] redirect_target;  // value actually loaded into the PC on redirect

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q;

  assign bad_align       = (redirect_pc_i[1:0] != 2'b00);
  assign redirect_target = redirect_pc_i;

  // Misalign cause is recorded on every redirect and cleared only by reset or a later redirect
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      misalign_q <= 1'b0;
    end else if (redirect_i) begin
      misalign_q <= bad_align;
    end
  end
`else
  assign bad_align       = 1'b0;
  assign redirect_target = redirect_pc_i & 32'hFFFF_FFFC;
`endif

  // Decode whether this edge may capture, and whether the PC is fetchable
  always_comb begin
    in_range = (pc_q <= LastWordAddr);
    capture  = (state_q == StRun) && (!valid_q || ready_i);
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a redirect wins over capture; only a redirect leaves HALT
  always_comb begin
    state_d = state_q;
    if (redirect_i) begin
      state_d = bad_align ? StHalt : StRun;
    end else if (capture && !in_range) begin
      state_d = StHalt;
    end
  end

  // Datapath next state: flush on redirect, otherwise capture or hold
  always_comb begin
    pc_d     = pc_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    if (redirect_i) begin
      pc_d    = redirect_target;
      valid_d = 1'b0;
    end else if (capture) begin
      if (in_range) begin
        instr_d  = imem_rdata_i;
        pc_out_d = pc_q;
        valid_d  = 1'b1;
        pc_d     = pc_q + 32'd4;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // PC and IF/ID pipeline register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      instr_q  <= NopInstr;
      pc_out_q <= 32'h0000_0000;
    end else begin
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
    end
  end

  // FSM outputs: fault is exactly "in HALT", since every HALT entry is a fault
  always_comb begin
    imem_addr_o = pc_q;
    valid_o     = valid_q;
    instr_o     = instr_q;
    pc_o        = pc_out_q;
    fault_o     = (state_q == StHalt);
`ifdef FETCH_ALIGN_CHECK_EN
    misalign_o  = misalign_q;
`else
    misalign_o  = 1'b0;
`endif
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage sitting directly upstream of the byte-addressed instruction memory: holds the program counter, drives the memory address, and registers the returned word into the IF/ID pipeline register for the decoder. It supports valid/ready back-pressure from decode, redirects from branches and jumps, and a halt on out-of-range fetch.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- MEM_BYTES, 1024, instruction memory size in bytes; the last legal word address is MEM_BYTES-4
- clk_i  input  1  clock; all state updates on the rising edge
- rst_i  input  1  synchronous, active-high reset
- imem_addr_o  output  32  byte address to the instruction memory; combinationally equal to the PC register
- imem_rdata_i  input  32  instruction word from the memory, combinational in the same cycle
- ready_i  input  1  decode accepts instr_o/pc_o this cycle
- redirect_i  input  1  branch/jump taken; flush and load a new PC
- redirect_pc_i  input  32  redirect target byte address
- valid_o  output  1  instr_o/pc_o hold a valid fetched instruction
- instr_o  output  32  registered instruction word
- pc_o  output  32  address that instr_o was fetched from
- fault_o  output  1  fetch halted (out of range, or misaligned when checking is enabled)
- misalign_o  output  1  halt cause was a misaligned redirect; tied 0 when FETCH_ALIGN_CHECK_EN is undefined

## Operation
- State machine states: RUN and HALT. Reset enters RUN.
- Reset values: PC=RESET_PC, valid_o=0, instr_o=32'h0000_0013 (NOP), pc_o=0, fault_o=0, misalign_o=0.
- Priority per edge: rst_i, then redirect_i, then capture/hold.
- Redirect (RUN or HALT):
  - PC <= redirect_pc_i and valid_o <= 0; the current output is discarded even if ready_i=1.
  - State <= RUN, and fault_o and misalign_o clear, except as described under Configuration.
- Capture (RUN, no redirect, and valid_o=0 or ready_i=1):
  - If PC <= MEM_BYTES-4: instr_o <= imem_rdata_i, pc_o <= PC, valid_o <= 1, PC <= PC+4 (32-bit, modulo 2^32).
  - Otherwise: valid_o <= 0, PC holds, state <= HALT, fault_o <= 1.
- Hold (valid_o=1 and ready_i=0): PC, instr_o, pc_o and valid_o remain unchanged.
- HALT: valid_o=0 and the PC is frozen. Only a redirect or reset leaves HALT.
- A handshake completes when valid_o and ready_i are both 1 on the same edge.

## Timing
- Fetch latency is 1 cycle. The address presented in cycle N appears on instr_o with valid_o=1 in cycle N+1.
- Throughput is one instruction per cycle while ready_i=1.
- A redirect asserted in cycle N gives imem_addr_o=target in N+1 (valid_o=0), and the target instruction is valid in N+2. This is a 1-cycle bubble.
- The cycle after rst_i deasserts has imem_addr_o=RESET_PC and valid_o=0. The first valid instruction appears one cycle later.
- Reset mid-stream discards any pending output immediately at the next edge.
- Out-of-range detection uses the PC in the capture cycle. fault_o rises one cycle later, on the same edge on which valid_o would otherwise have risen.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - A redirect with redirect_pc_i[1:0] != 0 loads the PC, enters HALT, and sets fault_o=1 and misalign_o=1 on the next edge.
  - No instruction from the misaligned address is ever marked valid.
- FETCH_ALIGN_CHECK_EN undefined:
  - redirect_pc_i[1:0] is forced to 2'b00 when loaded into the PC.
  - misalign_o is constant 0.

## Test plan
- Reset, then ready_i=1 for 4 cycles with memory words 0x00500093, 0x00100113, ... → pc_o sequence 0,4,8,12, valid_o=1 from the 2nd cycle after reset release, instr_o matching the memory.
- Back-pressure: ready_i=0 for 3 cycles while valid_o=1 at pc_o=8 → pc_o=8 and instr_o held, imem_addr_o stays 12, and the next accepted pc_o is 12.
- Redirect to 0x40 together with ready_i=1 while pc_o=4 → one cycle valid_o=0, then pc_o=0x40. The instruction at 8 never appears.
- Sequential run to PC=1024 with MEM_BYTES=1024 → last valid pc_o=1020, then valid_o=0, fault_o=1. Redirect to 0 clears fault_o and resumes at pc_o=0.
- Redirect to 0x22:
  - With FETCH_ALIGN_CHECK_EN: fault_o=1, misalign_o=1, and valid_o stays 0.
  - Without it: the next valid pc_o=0x20.
- Assert rst_i while valid_o=1 and ready_i=0 → next cycle valid_o=0, instr_o=0x00000013, imem_addr_o=RESET_PC.
